// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package display_pkg;

    localparam int unsigned N_DIGITS = 8;

    typedef logic [6:0] seg_t;

    localparam seg_t              SEG_BLANK = 7'h7F;
    localparam logic [N_DIGITS-1:0] AN_OFF  = 8'hFF;

endpackage

// File: rtl/display_scan_if.sv
// Digit data in, board-pin outputs back; master is the producer of the digit data.
interface display_scan_if;
    import display_pkg::*;

    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_n;
    logic [N_DIGITS-1:0]   digit_en;
    seg_t                  seg_n;
    logic                  dp_out_n;
    logic [N_DIGITS-1:0]   an_n;

    modport master (
        output value,
        output dp_n,
        output digit_en,
        input  seg_n,
        input  dp_out_n,
        input  an_n
    );

    modport slave (
        input  value,
        input  dp_n,
        input  digit_en,
        output seg_n,
        output dp_out_n,
        output an_n
    );

endinterface

// File: rtl/display_scan_hex_to_seg.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Free-running eight-digit scan: one digit lit per CLK_DIV-cycle slot, all outputs registered.
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned CLK_DIV = 100_000
) (
    input  logic          clk,
    input  logic          reset,
    display_scan_if.slave bus
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    seg_t                seg_q, seg_d;
    logic                dp_q, dp_d;

    logic                tick;
    logic [3:0]          nibble;
    seg_t                hex_seg;

    assign tick   = (cnt_q == CNT_LAST);
    assign nibble = bus.value[{idx_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            // Blanking overrides the decimal point as well as the segments.
            if (bus.digit_en[idx_q]) begin
                an_d  = ~(8'h01 << idx_q);
                seg_d = hex_seg;
                dp_d  = bus.dp_n[idx_q];
            end else begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an_n     = an_q;
    assign bus.seg_n    = seg_q;
    assign bus.dp_out_n = dp_q;

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed driver for the eight-digit, common-anode seven-segment display on the Nexys 4 DDR. It consumes eight hex nibbles, eight active-low decimal-point requests (one per digit, driven by the overflow-indicator logic) and a per-digit enable mask. It scans one digit at a time, producing active-low segment, decimal-point and anode outputs. It is the final stage before the board pins.

## Interface
- CLK_DIV, default 100_000 — clock cycles each digit is lit (1 ms at 100 MHz); legal range ≥ 2.
- clk  in  1  — system clock; all state changes on its rising edge.
- reset  in  1  — synchronous, active-high.
- value  in  32  — digit k shows value[4k+3:4k]; digit 0 is rightmost.
- dp_n  in  8  — active-low decimal-point request; bit k belongs to digit k.
- digit_en  in  8  — 1 = digit k displayed; 0 = digit k blanked for its time slot.
- seg_n  out  7  — {g,f,e,d,c,b,a}, active low.
- dp_out_n  out  1  — decimal point, active low.
- an_n  out  8  — anode select, active low; at most one bit low.

## Operation
- cnt counts 0..CLK_DIV-1 and wraps; tick = (cnt == CLK_DIV-1). Width is $clog2(CLK_DIV).
- idx is a 3-bit digit index. It starts at 0 and advances only on tick, 7 → 0 wrap.
- On the tick cycle, the output registers load the outputs for the current idx, then idx increments:
  - Enabled digit: an_n = ~(1<<idx), seg_n = hex_to_seg(value nibble idx), dp_out_n = dp_n[idx].
  - Blanked digit (digit_en[idx]=0): an_n = 8'hFF, seg_n = 7'h7F, dp_out_n = 1.
- Inputs are sampled only on tick. Changes between ticks have no effect until the next slot for that digit.
- Hex encoding, active low {g..a}:
  - 0 → 1000000
  - 1 → 1111001
  - 8 → 0000000
  - A → 0001000
  - F → 0001110
  - All 16 codes are defined. There is no illegal input.
- dp is independent of digit value, so dp_n[k]=0 with a blanked digit still shows nothing. Blanking wins.
- There is no FSM beyond the cnt/idx pair. The scan is free-running and never stalls.

## Timing
- Reset (sync, active-high) sets cnt=0, idx=0, an_n=8'hFF, seg_n=7'h7F, dp_out_n=1. Outputs stay dark until the first tick.
- First tick occurs on the CLK_DIV-th rising edge after reset deasserts (cnt reaches CLK_DIV-1). Digit 0 outputs become visible the following cycle.
- Each digit is then held for exactly CLK_DIV cycles. Full frame = 8·CLK_DIV cycles.
- Latency from input sampling (tick edge) to pin change is 1 cycle. All outputs are registered, so they are glitch-free.
- Reset asserted mid-frame takes effect on the next edge: outputs go dark and the scan restarts at digit 0 with cnt=0.
- Reset asserted on a tick cycle: reset has priority; no load occurs.
- Anode and segment registers update on the same edge. A change of digit never shows the previous digit's segments on the new anode.

## Structure
- Package display_pkg:
  - N_DIGITS = 8
  - typedef logic [6:0] seg_t
  - SEG_BLANK = 7'h7F
  - AN_OFF = 8'hFF
- Sub-module hex_to_seg: combinational, 4-bit nibble in, seg_t out. It is instantiated once and fed by the idx-selected nibble.
- Top holds cnt, idx, the nibble/dp mux and the output registers.

## Test plan
All scenarios use CLK_DIV=4 and digit_en=8'hFF unless stated.
1. Reset, then hold value=32'h76543210 and dp_n=8'hFF → an_n walks FE, FD, FB, … 7F every 4 cycles. seg_n matches codes 0..7. Outputs are dark (FF/7F/1) for the first 4 cycles after reset.
2. value=32'hFFFFFFFF, dp_n=8'b1111_1101 → dp_out_n=0 only while an_n=8'hFD. Every slot shows seg_n=0001110.
3. digit_en=8'h0F → slots 4..7 give an_n=8'hFF and seg_n=7'h7F, while each slot still lasts 4 cycles. With dp_n=8'h00, dp_out_n=0 only in slots 0..3.
4. Change value mid-slot (between ticks) → no output change until the next tick; the new nibble appears only when its digit's slot loads.
5. Assert reset for 1 cycle while digit 5 is lit → the next cycle shows dark outputs. Digit 0 appears 4 cycles after deassertion, followed by digit 1.
6. Run 3 full frames → an_n low bit 7 → bit 0 wraparound is observed. Exactly one an_n bit is low on every cycle after the first tick, and each value repeats with a period of 32 cycles.
